// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: ALU op selects, MIPS opcode/funct
// values, FSM states and branch types.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_NOR = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_ADD = 3'd5;
    localparam logic [2:0] ALU_SUB = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEQ  = 2'd1,
        BR_BNE  = 2'd2
    } br_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between the multicycle datapath (master)
// and the ALU issue controller (slave).
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_opcode;
    logic [5:0]        req_funct;
    logic [DATA_W-1:0] req_rs;
    logic [DATA_W-1:0] req_rt;
    logic [IMM_W-1:0]  req_imm;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_branch_taken;
    logic              rsp_illegal;

    modport master (
        output req_valid, req_opcode, req_funct, req_rs, req_rt, req_imm, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_branch_taken, rsp_illegal
    );

    modport slave (
        input  req_valid, req_opcode, req_funct, req_rs, req_rt, req_imm, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_branch_taken, rsp_illegal
    );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational MIPS opcode/funct decode into ALU select, operand-B source and
// branch type; anything not listed is flagged illegal.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctr,
    output logic       use_imm,
    output logic       sign_ext,
    output br_e        br_type,
    output logic       illegal
);

    always_comb begin
        alu_ctr  = ALU_AND;
        use_imm  = 1'b0;
        sign_ext = 1'b0;
        br_type  = BR_NONE;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctr = ALU_ADD;
                    FN_SUB:  alu_ctr = ALU_SUB;
                    FN_AND:  alu_ctr = ALU_AND;
                    FN_OR:   alu_ctr = ALU_OR;
                    FN_XOR:  alu_ctr = ALU_XOR;
                    FN_NOR:  alu_ctr = ALU_NOR;
                    FN_SLT:  alu_ctr = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                alu_ctr  = ALU_ADD;
                use_imm  = 1'b1;
                sign_ext = 1'b1;
            end
            OP_SLTI: begin
                alu_ctr  = ALU_SLT;
                use_imm  = 1'b1;
                sign_ext = 1'b1;
            end
            OP_ANDI: begin
                alu_ctr = ALU_AND;
                use_imm = 1'b1;
            end
            OP_ORI: begin
                alu_ctr = ALU_OR;
                use_imm = 1'b1;
            end
            OP_XORI: begin
                alu_ctr = ALU_XOR;
                use_imm = 1'b1;
            end
            OP_BEQ: begin
                alu_ctr = ALU_SUB;
                br_type = BR_BEQ;
            end
            OP_BNE: begin
                alu_ctr = ALU_SUB;
                br_type = BR_BNE;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded request to the external combinational ALU, captures its
// result one cycle later and holds the response until the datapath takes it.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_ctrl_if.slave   bus,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [2:0]        alu_ctr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              zero_bit
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
    logic [2:0]        ctr_q, ctr_d;
    br_e               br_q, br_d;
    logic              ill_q, ill_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_br_q, rsp_br_d;
    logic              rsp_ill_q, rsp_ill_d;

    logic [2:0]        dec_ctr;
    logic              dec_use_imm, dec_sign_ext, dec_illegal;
    br_e               dec_br;
    logic [DATA_W-1:0] imm_ext;
    logic              accept;

    alu_op_decoder u_dec (
        .opcode   (bus.req_opcode),
        .funct    (bus.req_funct),
        .alu_ctr  (dec_ctr),
        .use_imm  (dec_use_imm),
        .sign_ext (dec_sign_ext),
        .br_type  (dec_br),
        .illegal  (dec_illegal)
    );

    assign imm_ext = {{(DATA_W-IMM_W){dec_sign_ext & bus.req_imm[IMM_W-1]}}, bus.req_imm};
    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d      = state_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        ctr_d        = ctr_q;
        br_d         = br_q;
        ill_d        = ill_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_br_d     = rsp_br_q;
        rsp_ill_d    = rsp_ill_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    br_d    = dec_br;
                    ill_d   = dec_illegal;
                    // An illegal request leaves the ALU inputs where they were.
                    if (!dec_illegal) begin
                        src1_d = bus.req_rs;
                        src2_d = dec_use_imm ? imm_ext : bus.req_rt;
                        ctr_d  = dec_ctr;
                    end
                end
            end
            EXEC: begin
                rsp_result_d = ill_q ? '0 : alu_result;
                rsp_zero_d   = !ill_q && zero_bit;
                rsp_br_d     = ((br_q == BR_BEQ) && zero_bit) || ((br_q == BR_BNE) && !zero_bit);
                rsp_ill_d    = ill_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            src1_q       <= '0;
            src2_q       <= '0;
            ctr_q        <= ALU_AND;
            br_q         <= BR_NONE;
            ill_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_br_q     <= 1'b0;
            rsp_ill_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            ctr_q        <= ctr_d;
            br_q         <= br_d;
            ill_q        <= ill_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_br_q     <= rsp_br_d;
            rsp_ill_q    <= rsp_ill_d;
        end
    end

    assign alu_src1             = src1_q;
    assign alu_src2             = src2_q;
    assign alu_ctr              = ctr_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_result       = rsp_result_q;
    assign bus.rsp_zero         = rsp_zero_q;
    assign bus.rsp_branch_taken = rsp_br_q;
    assign bus.rsp_illegal      = rsp_ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the alu_* ports.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [2:0]  alu_ctr;
    logic        zero_bit;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DATA_W(32), .IMM_W(16)) bus ();

    alu_issue_ctrl #(.DATA_W(32), .IMM_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_ctr    (alu_ctr),
        .alu_result (alu_result),
        .zero_bit   (zero_bit)
    );

    always_comb begin
        alu_result = '0;
        case (alu_ctr)
            3'd0: alu_result = alu_src1 & alu_src2;
            3'd1: alu_result = alu_src1 | alu_src2;
            3'd2: alu_result = alu_src1 ^ alu_src2;
            3'd3: alu_result = ~(alu_src1 | alu_src2);
            3'd4: alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
            3'd5: alu_result = alu_src1 + alu_src2;
            3'd6: alu_result = alu_src1 - alu_src2;
            default: alu_result = '0;
        endcase
    end
    assign zero_bit = (alu_result == 32'd0);

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [2:0]  ctr;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] res;
        logic        z;
        logic        br;
        logic        ill;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        bus.req_opcode = v.op;
        bus.req_funct  = v.fn;
        bus.req_rs     = v.rs;
        bus.req_rt     = v.rt;
        bus.req_imm    = v.imm;
        bus.req_valid  = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        // Scramble request fields after the accept edge; they must be ignored.
        bus.req_valid = 1'b0;
        bus.req_rs    = ~v.rs;
        bus.req_rt    = ~v.rt;
        bus.req_imm   = ~v.imm;
        check({tag, "_alu_ctr"}, {29'd0, alu_ctr}, {29'd0, v.ctr});
        check({tag, "_alu_src1"}, alu_src1, v.s1);
        check({tag, "_alu_src2"}, alu_src2, v.s2);
        check({tag, "_busy"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd0);
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_latency"}, n, 32'd1);
        check({tag, "_result"}, bus.rsp_result, v.res);
        check({tag, "_flags"}, {29'd0, bus.rsp_zero, bus.rsp_branch_taken, bus.rsp_illegal},
              {29'd0, v.z, v.br, v.ill});
        @(posedge clk); #1;
        check({tag, "_release"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        //           op     fn     rs            rt            imm       ctr   s1            s2            res           z     br    ill
        vecs[0]  = '{6'h00, 6'h20, 32'd5,        32'd7,        16'h0000, 3'd5, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1'b0};
        vecs[1]  = '{6'h04, 6'h00, 32'h1234,     32'h1234,     16'h0000, 3'd6, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b1, 1'b0};
        vecs[2]  = '{6'h05, 6'h00, 32'h1234,     32'h1234,     16'h0000, 3'd6, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b0, 1'b0};
        vecs[3]  = '{6'h0C, 6'h00, 32'hFFFFFFFF, 32'd0,        16'h8000, 3'd0, 32'hFFFFFFFF, 32'h00008000, 32'h00008000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{6'h0A, 6'h00, 32'hFFFFFFFE, 32'd0,        16'hFFFF, 3'd4, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0};
        vecs[5]  = '{6'h3F, 6'h00, 32'd77,       32'd88,       16'h1234, 3'd4, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 1'b1};
        vecs[6]  = '{6'h00, 6'h00, 32'd77,       32'd88,       16'h1234, 3'd4, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 1'b1};
        vecs[7]  = '{6'h00, 6'h22, 32'd9,        32'd4,        16'h0000, 3'd6, 32'd9,        32'd4,        32'd5,        1'b0, 1'b0, 1'b0};
        vecs[8]  = '{6'h0D, 6'h00, 32'h00000F00, 32'd0,        16'h00F0, 3'd1, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{6'h0E, 6'h00, 32'hFFFF0000, 32'd0,        16'hFFFF, 3'd2, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{6'h00, 6'h27, 32'd0,        32'd0,        16'h0000, 3'd3, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{6'h23, 6'h00, 32'h00000100, 32'd0,        16'hFFFC, 3'd5, 32'h00000100, 32'hFFFFFFFC, 32'h000000FC, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{6'h08, 6'h00, 32'd1,        32'd0,        16'hFFFF, 3'd5, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0};
        vecs[13] = '{6'h05, 6'h00, 32'd1,        32'd2,        16'h0000, 3'd6, 32'd1,        32'd2,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_funct = '0;
        bus.req_rs = '0; bus.req_rt = '0; bus.req_imm = '0; bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, bus.req_ready}, 32'd0);
        check("reset_alu", alu_src1 | alu_src2 | {29'd0, alu_ctr}, 32'd0);
        check("reset_rsp", {27'd0, bus.rsp_valid, bus.rsp_zero, bus.rsp_branch_taken,
              bus.rsp_illegal, |bus.rsp_result}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_reset_ready", {31'd0, bus.req_ready}, 32'd1);

        // rsp_ready held high from before any response exists.
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Backpressure: response must hold while the consumer stalls.
        bus.rsp_ready = 1'b0;
        bus.req_opcode = 6'h00; bus.req_funct = 6'h20;
        bus.req_rs = 32'd3; bus.req_rt = 32'd4; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        check("bp_latency", n, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_ctl", c), {30'd0, bus.rsp_valid, bus.req_ready}, 32'd2);
            check($sformatf("bp_hold%0d_result", c), bus.rsp_result, 32'd7);
            check($sformatf("bp_hold%0d_flags", c),
                  {29'd0, bus.rsp_zero, bus.rsp_branch_taken, bus.rsp_illegal}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);

        // Reset landing on the EXEC cycle aborts the request.
        bus.req_opcode = 6'h00; bus.req_funct = 6'h22;
        bus.req_rs = 32'd9; bus.req_rt = 32'd4; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("abort_exec_src1", alu_src1, 32'd9);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_alu", alu_src1 | alu_src2 | {29'd0, alu_ctr}, 32'd0);
        check("abort_rsp", {26'd0, bus.req_ready, bus.rsp_valid, bus.rsp_zero,
              bus.rsp_branch_taken, bus.rsp_illegal, |bus.rsp_result}, 32'd0);
        reset = 1'b0;
        n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) n++;
        end
        check("abort_no_rsp", n, 32'd0);
        run_vec(vecs[7], "after_abort");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
